// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises rx, samples each bit at mid-bit and queues
// received bytes in a show-ahead FIFO with sticky framing/overrun flags.
module uart_rx #(
    parameter int unsigned CmpVal    = 173,
    parameter int unsigned DataWidth = 8,
    parameter int unsigned Depth     = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       rx,
    input  logic                       rx_pop,
    input  logic                       err_clr,
    output logic [DataWidth-1:0]       rx_data,
    output logic                       rx_valid,
    output logic [$clog2(Depth):0]     rx_count,
    output logic                       frame_err,
    output logic                       overrun,
    output logic                       busy
);

    localparam int unsigned AddrW   = $clog2(Depth);
    localparam int unsigned CntW    = $clog2(CmpVal);
    localparam int unsigned IdxW    = (DataWidth > 1) ? $clog2(DataWidth) : 1;
    localparam int unsigned HalfVal = CmpVal / 2;

    typedef enum logic [1:0] {
        Idle,
        Start,
        Data,
        Stop
    } stateT;

    stateT                 state;
    logic                  rxMeta;
    logic                  rxSync;
    logic                  rxDly;
    logic [CntW-1:0]       bitCnt;
    logic [IdxW-1:0]       bitIdx;
    logic [DataWidth-1:0]  shiftReg;
    logic [DataWidth-1:0]  mem [Depth];
    logic [AddrW:0]        wrPtr;
    logic [AddrW:0]        rdPtr;
    logic                  frameErrQ;
    logic                  overrunQ;

    logic fifoEmpty;
    logic fifoFull;
    logic popEn;
    logic stopHit;
    logic pushReq;
    logic pushEn;
    logic dropEn;
    logic badStop;

    // FIFO status and push/pop qualification
    always_comb begin
        fifoEmpty = (wrPtr == rdPtr);
        fifoFull  = (wrPtr[AddrW] != rdPtr[AddrW]) &&
                    (wrPtr[AddrW-1:0] == rdPtr[AddrW-1:0]);
        popEn     = rx_pop && !fifoEmpty;
        stopHit   = (state == Stop) && (bitCnt == CntW'(CmpVal - 1));
        pushReq   = stopHit && rxSync;
        badStop   = stopHit && !rxSync;
        pushEn    = pushReq && (!fifoFull || popEn);
        dropEn    = pushReq && fifoFull && !popEn;
    end

    assign rx_data   = fifoEmpty ? '0 : mem[rdPtr[AddrW-1:0]];
    assign rx_valid  = !fifoEmpty;
    assign rx_count  = wrPtr - rdPtr;
    assign frame_err = frameErrQ;
    assign overrun   = overrunQ;
    assign busy      = (state != Idle);

    // Two-flop synchroniser plus delayed copy for falling-edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxMeta <= 1'b1;
            rxSync <= 1'b1;
            rxDly  <= 1'b1;
        end else begin
            rxMeta <= rx;
            rxSync <= rxMeta;
            rxDly  <= rxSync;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= Idle;
            bitCnt    <= '0;
            bitIdx    <= '0;
            shiftReg  <= '0;
            wrPtr     <= '0;
            rdPtr     <= '0;
            frameErrQ <= 1'b0;
            overrunQ  <= 1'b0;
        end else begin
            case (state)
                Idle: begin
                    if (rxDly && !rxSync) begin
                        state  <= Start;
                        bitCnt <= '0;
                    end
                end
                Start: begin
                    if (bitCnt == CntW'(HalfVal - 1)) begin
                        bitCnt <= '0;
                        bitIdx <= '0;
                        state  <= rxSync ? Idle : Data;
                    end else begin
                        bitCnt <= bitCnt + 1'b1;
                    end
                end
                Data: begin
                    if (bitCnt == CntW'(CmpVal - 1)) begin
                        bitCnt   <= '0;
                        shiftReg <= {rxSync, shiftReg[DataWidth-1:1]};
                        if (bitIdx == IdxW'(DataWidth - 1)) begin
                            state <= Stop;
                        end else begin
                            bitIdx <= bitIdx + 1'b1;
                        end
                    end else begin
                        bitCnt <= bitCnt + 1'b1;
                    end
                end
                Stop: begin
                    // Back to Idle on the sample edge so the next start edge is not missed
                    if (stopHit) begin
                        bitCnt <= '0;
                        state  <= Idle;
                    end else begin
                        bitCnt <= bitCnt + 1'b1;
                    end
                end
                default: state <= Idle;
            endcase

            if (pushEn) wrPtr <= wrPtr + 1'b1;
            if (popEn)  rdPtr <= rdPtr + 1'b1;

            frameErrQ <= badStop || (frameErrQ && !err_clr);
            overrunQ  <= dropEn  || (overrunQ  && !err_clr);
        end
    end

    // FIFO storage carries no reset; rx_data is masked while empty
    always_ff @(posedge clk) begin
        if (pushEn) mem[wrPtr[AddrW-1:0]] <= shiftReg;
    end

endmodule
